// File: rtl/game_timer_pkg.sv
// Shared types and constants for the countdown game timer.
package game_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } digits_t;

  localparam int unsigned WARN_SEC = 10;

  // Split a number of seconds into MM:SS BCD digits.
  function automatic digits_t to_bcd(input int unsigned sec);
    digits_t d;
    d.min_tens = 4'((sec / 600) % 10);
    d.min_ones = 4'((sec / 60) % 10);
    d.sec_tens = 4'((sec % 60) / 10);
    d.sec_ones = 4'(sec % 10);
    return d;
  endfunction

endpackage

// File: rtl/game_timer_tick_sync.sv
// Synchronizes the slow divider output and turns its rising edges into one-cycle ticks.
module tick_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic sync_level,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  // Shift the raw level through the chain; history holds the previous synced level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tick_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and history flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign tick       = sync_level & ~hist_q;

endmodule

// File: rtl/game_timer.sv
// MM:SS BCD countdown timer driven by the 1 Hz divider output.
// Optional low-time blink on warn is built when GAME_TIMER_WARN_EN is defined.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned START_SEC   = 60,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       timeout,
  output logic       warn
);

  localparam digits_t START_DIGITS = to_bcd(START_SEC);
  localparam digits_t ONE_DIGITS   = to_bcd(1);

  state_e  state_q, state_d;
  digits_t cnt_q, cnt_d;
  digits_t cnt_dec;
  logic    running_q, running_d;
  logic    timeout_q, timeout_d;
  logic    warn_q, warn_d;
  logic    sync_level;
  logic    tick;

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .sync_level (sync_level),
    .tick       (tick)
  );

  // One-second BCD decrement with borrow across the four digits.
  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q.sec_ones != 4'd0) begin
      cnt_dec.sec_ones = cnt_q.sec_ones - 4'd1;
    end else begin
      cnt_dec.sec_ones = 4'd9;
      if (cnt_q.sec_tens != 4'd0) begin
        cnt_dec.sec_tens = cnt_q.sec_tens - 4'd1;
      end else begin
        cnt_dec.sec_tens = 4'd5;
        if (cnt_q.min_ones != 4'd0) begin
          cnt_dec.min_ones = cnt_q.min_ones - 4'd1;
        end else begin
          cnt_dec.min_ones = 4'd9;
          cnt_dec.min_tens = cnt_q.min_tens - 4'd1;
        end
      end
    end
  end

  // Next state, counter update and registered output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d   = START_DIGITS;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          cnt_d = cnt_dec;
          // Reaching zero takes precedence over a coincident pause.
          if (cnt_q == ONE_DIGITS) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end else if (pause) begin
            state_d = PAUSE;
          end
        end else if (pause) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
`ifdef GAME_TIMER_WARN_EN
    warn_d = sync_level && ((state_q == RUN) || (state_q == PAUSE)) &&
             (cnt_q != '0) && (cnt_q <= to_bcd(WARN_SEC));
`else
    warn_d = 1'b0;
`endif
  end

`ifndef GAME_TIMER_WARN_EN
  logic sync_level_unused;
  assign sync_level_unused = sync_level;
`endif

  // State, digit and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= START_DIGITS;
      running_q <= 1'b0;
      timeout_q <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      timeout_q <= timeout_d;
      warn_q    <= warn_d;
    end
  end

  assign min_tens = cnt_q.min_tens;
  assign min_ones = cnt_q.min_ones;
  assign sec_tens = cnt_q.sec_tens;
  assign sec_ones = cnt_q.sec_ones;
  assign running  = running_q;
  assign timeout  = timeout_q;
  assign warn     = warn_q;

endmodule

// File: doc/game_timer.md
# game_timer

Countdown game timer that sits directly downstream of the 1 Hz clock divider. It treats the divider's slow square-wave output as data, not as a clock: it synchronizes it, edge-detects it into single-cycle ticks, and counts a MM:SS value down in BCD. Its outputs drive the seven-segment display and the game-over logic.

## Interface
- START_SEC, default 60: value loaded at reset and on start, in seconds; legal range 1..5999.
- SYNC_STAGES, default 2: number of synchronizer flops on tick_in; minimum 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick_in  in  1  divider output, a square wave with one rising edge per second.
- start  in  1  level sampled each cycle; loads and runs from IDLE/DONE, resumes from PAUSE.
- pause  in  1  level sampled each cycle; RUN -> PAUSE.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits of the remaining time.
- running  out  1  high while in RUN.
- timeout  out  1  one-cycle pulse when the count reaches 00:00.
- warn  out  1  low-time blink indicator; see Configuration.

## Operation
- Tick path:
  - tick_in passes through SYNC_STAGES flops plus one history flop.
  - tick = sync_out & ~history.
  - The tick path runs in every state, so resuming never produces a stale or spurious tick.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE / DONE, start=1: load START_SEC into the digits and go to RUN.
  - RUN, pause=1: go to PAUSE.
  - RUN, tick at value 00:01: go to DONE.
  - PAUSE, start=1: go to RUN. The digits are not reloaded.
  - Other inputs in each state are ignored.
- Decrement happens only in RUN and only on a tick, using BCD borrow:
  - sec_ones 0 -> 9 with a borrow.
  - sec_tens 0 -> 5 with a borrow.
  - min_ones 0 -> 9 with a borrow.
  - min_tens decrements.
  - Digits never exceed 5 in sec_tens or 9 in any other digit.
- Entering DONE:
  - The digits hold 00:00.
  - timeout is high for exactly the cycle after the transition edge.
- Simultaneous events:
  - start and pause together: start wins in IDLE, DONE and PAUSE; pause wins in RUN.
  - tick and pause together in RUN: the decrement is applied and the state goes to PAUSE.
  - tick and start together in IDLE/DONE: the load is applied and the tick is dropped.
- The first second after start may be partial; the first decrement occurs on the next tick.
- Reset, including mid-count:
  - State goes to IDLE and the digits to START_SEC in BCD.
  - running, timeout, warn and all sync/history flops go to 0.

## Timing
- Tick latency: the digits change on the (SYNC_STAGES+1)-th rising clk edge, counting the first edge that samples tick_in high. With the default, that is the 3rd edge.
- start/pause act on the next rising edge. running follows the state with no extra delay.
- timeout asserts in the same cycle that the digits first show 00:00, and deasserts one cycle later.
- Everything is synchronous to clk except rst.

## Configuration
- GAME_TIMER_WARN_EN defined:
  - warn = synchronized tick_in level while the state is RUN or PAUSE and the remaining time is ≤ 00:10 and > 00:00.
  - Otherwise warn = 0.
  - This gives a 1 Hz, 50 % blink.
- GAME_TIMER_WARN_EN undefined: the warn port still exists, tied to 0. No comparison logic is built.

## Structure
- Package game_timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - bcd_t typedef (logic [3:0]);
  - a constant function that converts seconds into the four START digits;
  - WARN_SEC = 10.
- Sub-module tick_sync, parameterized by SYNC_STAGES:
  - contains the synchronizer chain, history flop and rising-edge detector;
  - outputs sync_level and tick.
- game_timer contains the FSM, the BCD counter and the output logic.

## Test plan
- Reset with START_SEC=65: digits read 0,1,0,5; running=0, timeout=0. Asserting rst mid-count restores these values asynchronously.
- Start, then drive 3 tick_in rising edges: digits read 01:02. Each change lands exactly 3 clk edges after tick_in is sampled high.
- Borrow check: START_SEC=600 (10:00), one tick -> 09:59. Also 01:00 -> 00:59.
- START_SEC=3, run 3 ticks:
  - final value 00:00, state DONE;
  - timeout is high for exactly 1 cycle;
  - running drops;
  - further ticks leave 00:00 unchanged.
- Pause at 00:50, apply 5 ticks: the value stays 00:50. Start resumes and the next tick gives 00:49. pause coinciding with a tick gives 00:48 and PAUSE.
- With GAME_TIMER_WARN_EN, running at 00:10: warn tracks tick_in (delayed by sync) and is 0 at 00:11 and in DONE. Without the macro, warn is always 0.
